// File: rtl/fixed_p_pkg.sv
// Shared types and helpers for the fixed-point divider family.
// Combinational only (no latency); no flow control involved.
// State encoding for the divider FSM plus the iteration-count helper.
package fixed_p_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} fixed_p_div_state_t;

  // One restoring step per bit of the extended dividend {left, fract_width'b0}.
  function automatic int div_iters(input int width, input int fract_width);
    return width + fract_width;
  endfunction

endpackage

// File: rtl/fixed_p_div_step.sv
// Single restoring division step: shift one dividend bit into the partial remainder, trial-subtract.
// Purely combinational, zero latency.
// No backpressure; evaluated every cycle by the owning FSM.
module fixed_p_div_step #(
  parameter int width = 32
) (
  input  logic [width:0]   prem,
  input  logic             din,
  input  logic [width-1:0] divisor,
  output logic [width:0]   prem_nxt,
  output logic             qbit
);

  logic [width+1:0] shifted;
  logic [width:0]   diff;

  assign shifted = {prem, din};
  assign qbit    = shifted >= (width+2)'(divisor);
  // When the trial subtraction succeeds the result always fits in width+1 bits.
  assign diff     = shifted[width:0] - {1'b0, divisor};
  assign prem_nxt = qbit ? diff : shifted[width:0];

endmodule

// File: rtl/fixed_p_std_div_pipe.sv
// Iterative unsigned fixed-point divider (restoring, one quotient bit per cycle), go/done handshake.
// Latency: width+fract_width+1 cycles from go to done (1 cycle on divide-by-zero); II = width+fract_width+2.
// No backpressure: go is only sampled in IDLE; `FIXED_P_DIV_STATUS_EN adds div_by_zero/overflow outputs.
module fixed_p_std_div_pipe
  import fixed_p_pkg::*;
#(
  parameter int width       = 32,
  parameter int int_width   = 8,
  parameter int fract_width = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [width-1:0] left,
  input  logic [width-1:0] right,
  output logic [width-1:0] out_quotient,
  output logic [width-1:0] out_remainder,
`ifdef FIXED_P_DIV_STATUS_EN
  output logic             div_by_zero,
  output logic             overflow,
`endif
  output logic             done
);

  localparam int n_iter = div_iters(width, fract_width);
  localparam int cnt_w  = (n_iter > 1) ? $clog2(n_iter) : 1;
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(n_iter - 1);

  if (int_width + fract_width != width) begin : g_fmt_chk
    $error("fixed_p_std_div_pipe: int_width + fract_width must equal width");
  end

  fixed_p_div_state_t state, state_nxt;

  // dq_q starts as the extended dividend; quotient bits fill in from the LSB as dividend bits leave the MSB.
  logic [n_iter-1:0] dq_q;
  logic [n_iter-1:0] q_nxt;
  logic [width-1:0]  divisor_q;
  logic [width:0]    prem_q;
  logic [width:0]    step_rem;
  logic              step_q;
  logic [cnt_w-1:0]  cnt_q;

  fixed_p_div_step #(.width(width)) u_step (
    .prem     (prem_q),
    .din      (dq_q[n_iter-1]),
    .divisor  (divisor_q),
    .prem_nxt (step_rem),
    .qbit     (step_q)
  );

  assign q_nxt = {dq_q[n_iter-2:0], step_q};
  assign done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = (right == '0) ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dq_q          <= '0;
      divisor_q     <= '0;
      prem_q        <= '0;
      cnt_q         <= '0;
      out_quotient  <= '0;
      out_remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            dq_q      <= n_iter'(left) << fract_width;
            divisor_q <= right;
            prem_q    <= '0;
            cnt_q     <= last_cnt;
            if (right == '0) begin
              cnt_q         <= '0;
              out_quotient  <= '1;
              out_remainder <= left;
            end
          end
        end
        CALC: begin
          dq_q   <= q_nxt;
          prem_q <= step_rem;
          if (cnt_q == '0) begin
            // Results are registered on the final step so they are valid while done is high.
            out_quotient  <= q_nxt[width-1:0];
            out_remainder <= step_rem[width-1:0];
          end else begin
            cnt_q <= cnt_q - cnt_w'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIXED_P_DIV_STATUS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (state == IDLE && go && right == '0) begin
      div_by_zero <= 1'b1;
      overflow    <= 1'b1;
    end else if (state == CALC && cnt_q == '0) begin
      div_by_zero <= 1'b0;
      overflow    <= (q_nxt >> width) != '0;
    end
  end
`endif

endmodule

// File: tb/tb_fixed_p_std_div_pipe.sv
// Directed bench for fixed_p_std_div_pipe (Q8.24): latency, results, reset abort, back-to-back go.
module tb_fixed_p_std_div_pipe;

  logic        clk;
  logic        reset;
  logic        go;
  logic [31:0] left;
  logic [31:0] right;
  logic [31:0] out_quotient;
  logic [31:0] out_remainder;
  logic        done;
`ifdef FIXED_P_DIV_STATUS_EN
  logic        div_by_zero;
  logic        overflow;
`endif

  int checks = 0;
  int errors = 0;

  fixed_p_std_div_pipe #(.width(32), .int_width(8), .fract_width(24)) dut (
    .clk           (clk),
    .reset         (reset),
    .go            (go),
    .left          (left),
    .right         (right),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
`ifdef FIXED_P_DIV_STATUS_EN
    .div_by_zero   (div_by_zero),
    .overflow      (overflow),
`endif
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one operation, count cycles from the go-sampling edge, then check results.
  task automatic run_op(input string tag, input logic [31:0] l, input logic [31:0] r,
                        input logic [31:0] exp_q, input logic [31:0] exp_r, input int exp_lat,
                        input logic exp_ovf);
    int c;
    @(negedge clk);
    left  = l;
    right = r;
    go    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    left  = 32'hDEAD_BEEF;
    right = 32'h0000_0007;
    c = 1;
    while (!done && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_lat"}, 64'(c), 64'(exp_lat));
    chk({tag, "_q"}, 64'(out_quotient), 64'(exp_q));
    chk({tag, "_r"}, 64'(out_remainder), 64'(exp_r));
`ifdef FIXED_P_DIV_STATUS_EN
    chk({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(r == 32'h0));
`else
    if (exp_ovf === 1'bx) $display("unreachable");
`endif
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_hold_q"}, 64'(out_quotient), 64'(exp_q));
  endtask

  initial begin : main
    int  n_pulse;
    bit  prev_done;
    bit  consec;
    bit  seen;

    reset = 1'b0;
    go    = 1'b0;
    left  = '0;
    right = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_q", 64'(out_quotient), 64'd0);
    chk("rst_r", 64'(out_remainder), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset = 1'b1;

    run_op("six_by_two",  32'h0600_0000, 32'h0200_0000, 32'h0300_0000, 32'h0000_0000, 57, 1'b0);
    run_op("one_by_three", 32'h0100_0000, 32'h0300_0000, 32'h0055_5555, 32'h0100_0000, 57, 1'b0);
    run_op("ovf_big",     32'h8000_0000, 32'h0080_0000, 32'h0000_0000, 32'h0000_0000, 57, 1'b1);
    run_op("div_zero",    32'h0500_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0500_0000, 1,  1'b1);
    run_op("tiny_by_max", 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0100_0000, 57, 1'b0);
    run_op("max_by_one",  32'hFFFF_FFFF, 32'h0100_0000, 32'hFFFF_FFFF, 32'h0000_0000, 57, 1'b0);
    run_op("max_by_ulp",  32'hFFFF_FFFF, 32'h0000_0001, 32'hFF00_0000, 32'h0000_0000, 57, 1'b1);
    run_op("frac_div",    32'h0780_0000, 32'h0280_0000, 32'h0300_0000, 32'h0000_0000, 57, 1'b0);

    // Abort an in-flight operation with reset at cycle 20.
    @(negedge clk);
    left  = 32'h0600_0000;
    right = 32'h0200_0000;
    go    = 1'b1;
    @(posedge clk);
    seen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      go = 1'b0;
      if (done) seen = 1'b1;
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_q", 64'(out_quotient), 64'd0);
    chk("abort_r", 64'(out_remainder), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
`ifdef FIXED_P_DIV_STATUS_EN
    chk("abort_ovf", 64'(overflow), 64'd0);
    chk("abort_dbz", 64'(div_by_zero), 64'd0);
`endif
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    run_op("after_abort", 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0000_0000, 57, 1'b0);

    // Back-to-back with go held high and operands changing mid-calculation.
    @(negedge clk);
    left  = 32'h0600_0000;
    right = 32'h0200_0000;
    go    = 1'b1;
    @(posedge clk);
    n_pulse   = 0;
    prev_done = 1'b0;
    consec    = 1'b0;
    for (int c = 1; c <= 130; c++) begin
      @(negedge clk);
      if (done && prev_done) consec = 1'b1;
      prev_done = done;
      if (done) begin
        n_pulse++;
        if (n_pulse == 1) begin
          chk("b2b_first_at", 64'(c), 64'd57);
          chk("b2b_first_q", 64'(out_quotient), 64'h0300_0000);
          chk("b2b_first_r", 64'(out_remainder), 64'h0);
        end else begin
          chk("b2b_second_at", 64'(c), 64'd115);
          chk("b2b_second_q", 64'(out_quotient), 64'h0055_5555);
          chk("b2b_second_r", 64'(out_remainder), 64'h0100_0000);
          go = 1'b0;
        end
      end
      if (c == 1) begin
        left  = 32'h0100_0000;
        right = 32'h0300_0000;
      end
      if (c == 60) begin
        left  = 32'h0F00_0000;
        right = 32'h0500_0000;
      end
    end
    chk("b2b_pulses", 64'(n_pulse), 64'd2);
    chk("b2b_no_consec", 64'(consec), 64'd0);
    go = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
